// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the memory access controller.
package mem_access_ctrl_pkg;

  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    RD_WAIT = 3'd2,
    WR_LOAD = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5,
    ERR     = 3'd6
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_wait_timer.sv
// Wait-cycle counter with clear, enable and terminal count at TIMEOUT-1.
module mem_access_ctrl_wait_timer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic clr_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences one MAR/MDR memory transaction at a time with a bounded ready wait.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic clr_n,
  input  logic req_rd,
  input  logic req_wr,
  input  logic mem_ready,
  input  logic err_clr,
  output logic MARin,
  output logic MDRin,
  output logic Read,
  output logic mem_rd,
  output logic mem_wr,
  output logic busy,
  output logic done,
  output logic err
);

  state_t state, state_nxt;
  logic   op_rd;
  logic   waiting;
  logic   tc;

  assign waiting = (state == RD_WAIT) || (state == WR_WAIT);

  mem_access_ctrl_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_timer (
    .clk   (clk),
    .clr_n (clr_n),
    .clr   (!waiting),
    .en    (waiting && !mem_ready),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
      op_rd <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (req_rd || req_wr)) op_rd <= req_rd;
    end
  end

  // Set in ERR takes priority over a simultaneous clear request.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)             err <= 1'b0;
    else if (state == ERR)  err <= 1'b1;
    else if (err_clr)       err <= 1'b0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_rd || req_wr) state_nxt = ADDR;
      ADDR:    state_nxt = op_rd ? RD_WAIT : WR_LOAD;
      RD_WAIT: if (mem_ready) state_nxt = DONE;
               else if (tc)   state_nxt = ERR;
      WR_LOAD: state_nxt = WR_WAIT;
      WR_WAIT: if (mem_ready) state_nxt = DONE;
               else if (tc)   state_nxt = ERR;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    MARin  = (state == ADDR);
    mem_rd = (state == RD_WAIT);
    mem_wr = (state == WR_WAIT);
    Read   = (state == RD_WAIT) && mem_ready;
    MDRin  = ((state == RD_WAIT) && mem_ready) || (state == WR_LOAD);
    busy   = (state != IDLE);
    done   = (state == DONE);
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a bench-side MDR model.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic clr_n, req_rd, req_wr, mem_ready, err_clr;
  logic MARin, MDRin, Read, mem_rd, mem_wr, busy, done, err;
  logic [31:0] mdatain, bus, mdr;
  logic [7:0]  obs;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .clr_n(clr_n), .req_rd(req_rd), .req_wr(req_wr),
    .mem_ready(mem_ready), .err_clr(err_clr), .MARin(MARin), .MDRin(MDRin),
    .Read(Read), .mem_rd(mem_rd), .mem_wr(mem_wr), .busy(busy), .done(done),
    .err(err)
  );

  // Datapath stand-in: MDR loads Mdatain or BusMuxOut when MDRin is high.
  always @(posedge clk) if (MDRin) mdr <= Read ? mdatain : bus;

  assign obs = {MARin, MDRin, Read, mem_rd, mem_wr, busy, done, err};

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    clr_n = 1'b0; req_rd = 0; req_wr = 0; mem_ready = 0; err_clr = 0;
    mdatain = 32'h0; bus = 32'h0; mdr = 32'h0;
    #3;
    compared++;
    if (obs !== 8'b0) begin
      mismatched++; $display("FAIL reset_outputs got %b want %b", obs, 8'b0);
    end
    tick; tick;
    clr_n = 1'b1;
    tick; #1;
    compared++;
    if (obs !== 8'b0) begin
      mismatched++; $display("FAIL reset_release got %b want %b", obs, 8'b0);
    end
  endtask

  task automatic test_read_zero_wait;
    mem_ready = 1; mdatain = 32'h0000_1234; req_rd = 1;
    tick; req_rd = 0; #1;
    compared++;
    if (obs !== 8'b1000_0100) begin
      mismatched++; $display("FAIL rd0_cycle1 got %b want %b", obs, 8'b1000_0100);
    end
    tick; #1;
    compared++;
    if (obs !== 8'b0111_0100) begin
      mismatched++; $display("FAIL rd0_cycle2 got %b want %b", obs, 8'b0111_0100);
    end
    tick; #1;
    compared++;
    if (obs !== 8'b0000_0110) begin
      mismatched++; $display("FAIL rd0_cycle3 got %b want %b", obs, 8'b0000_0110);
    end
    tick; #1;
    compared++;
    if (obs !== 8'b0 || mdr !== 32'h0000_1234) begin
      mismatched++; $display("FAIL rd0_cycle4 got %b mdr %h want %b mdr %h", obs, mdr, 8'b0, 32'h1234);
    end
    mem_ready = 0;
  endtask

  task automatic test_write_wait3;
    mem_ready = 0; bus = 32'hDEAD_BEEF; mdatain = 32'h5555_5555; req_wr = 1;
    tick; req_wr = 0; #1;
    compared++;
    if (obs !== 8'b1000_0100) begin
      mismatched++; $display("FAIL wr_cycle1 got %b want %b", obs, 8'b1000_0100);
    end
    tick; #1;
    compared++;
    if (obs !== 8'b0100_0100) begin
      mismatched++; $display("FAIL wr_cycle2 got %b want %b", obs, 8'b0100_0100);
    end
    for (int c = 3; c <= 6; c++) begin
      tick;
      mem_ready = (c == 6);
      #1;
      compared++;
      if (obs !== 8'b0000_1100) begin
        mismatched++; $display("FAIL wr_wait_cycle%0d got %b want %b", c, obs, 8'b0000_1100);
      end
    end
    tick; mem_ready = 0; #1;
    compared++;
    if (obs !== 8'b0000_0110 || mdr !== 32'hDEAD_BEEF) begin
      mismatched++; $display("FAIL wr_done got %b mdr %h want %b mdr %h", obs, mdr, 8'b0000_0110, 32'hDEAD_BEEF);
    end
    tick; #1;
    compared++;
    if (busy !== 1'b0) begin
      mismatched++; $display("FAIL wr_idle busy got %b want 0", busy);
    end
  endtask

  task automatic test_timeout;
    int n_rd, n_mdr, n_done, n_drop;
    n_rd = 0; n_mdr = 0; n_done = 0; n_drop = 0;
    mem_ready = 0; req_rd = 1;
    tick; req_rd = 0; #1;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (i == 5) err_clr = 0;
      #1;
      if (mem_rd) n_rd++;
      if (MDRin) n_mdr++;
      if (done) n_done++;
      if (i == 4) begin
        compared++;
        if (obs !== 8'b0000_0100) begin
          mismatched++; $display("FAIL to_err_state got %b want %b", obs, 8'b0000_0100);
        end
        err_clr = 1;
      end
    end
    compared++;
    if (n_rd != 4 || n_mdr != 0 || n_done != 0) begin
      mismatched++; $display("FAIL to_strobes got rd=%0d mdr=%0d done=%0d want rd=4 mdr=0 done=0", n_rd, n_mdr, n_done);
    end
    compared++;
    if (obs !== 8'b0000_0001) begin
      mismatched++; $display("FAIL to_err_set got %b want %b", obs, 8'b0000_0001);
    end
    for (int i = 0; i < 10; i++) begin
      tick;
      if (err !== 1'b1) n_drop++;
    end
    compared++;
    if (n_drop != 0) begin
      mismatched++; $display("FAIL to_err_sticky got %0d drops want 0", n_drop);
    end
    err_clr = 1;
    tick; err_clr = 0; #1;
    compared++;
    if (err !== 1'b0) begin
      mismatched++; $display("FAIL to_err_clear got %b want 0", err);
    end
  endtask

  task automatic test_simul_ignored;
    int n_busy;
    n_busy = 0;
    mem_ready = 0; mdatain = 32'h0000_00AA; req_rd = 1; req_wr = 1;
    tick; req_rd = 0; req_wr = 0;
    tick; #1;
    compared++;
    if (obs !== 8'b0001_0100) begin
      mismatched++; $display("FAIL both_req_read got %b want %b", obs, 8'b0001_0100);
    end
    req_wr = 1;
    tick; req_wr = 0; mem_ready = 1; #1;
    compared++;
    if (obs !== 8'b0111_0100) begin
      mismatched++; $display("FAIL both_req_complete got %b want %b", obs, 8'b0111_0100);
    end
    tick; mem_ready = 0; #1;
    compared++;
    if (done !== 1'b1 || mdr !== 32'h0000_00AA) begin
      mismatched++; $display("FAIL both_req_done got done=%b mdr %h want done=1 mdr %h", done, mdr, 32'hAA);
    end
    for (int i = 0; i < 5; i++) begin
      tick;
      if (busy !== 1'b0) n_busy++;
    end
    compared++;
    if (n_busy != 0) begin
      mismatched++; $display("FAIL ignored_req got %0d busy cycles want 0", n_busy);
    end
  endtask

  task automatic test_reset_mid_op;
    mem_ready = 0; bus = 32'h1111_2222; req_wr = 1;
    tick; req_wr = 0;
    tick; tick; #1;
    compared++;
    if (mem_wr !== 1'b1) begin
      mismatched++; $display("FAIL rst_mid_pre mem_wr got %b want 1", mem_wr);
    end
    clr_n = 0; #1;
    compared++;
    if (obs !== 8'b0) begin
      mismatched++; $display("FAIL rst_mid_async got %b want %b", obs, 8'b0);
    end
    tick; #2; clr_n = 1;
    tick;
    mem_ready = 1; mdatain = 32'h0000_7777; req_rd = 1;
    tick; req_rd = 0;
    tick; tick; #1;
    compared++;
    if (obs !== 8'b0000_0110 || mdr !== 32'h0000_7777) begin
      mismatched++; $display("FAIL rst_mid_recover got %b mdr %h want %b mdr %h", obs, mdr, 8'b0000_0110, 32'h7777);
    end
    tick; mem_ready = 0;
  endtask

  task automatic test_spurious_ready;
    mem_ready = 1; mdatain = 32'h0000_CAFE;
    tick; #1;
    compared++;
    if (obs !== 8'b0) begin
      mismatched++; $display("FAIL spur_idle got %b want %b", obs, 8'b0);
    end
    req_rd = 1;
    tick; req_rd = 0; #1;
    compared++;
    if (obs !== 8'b1000_0100) begin
      mismatched++; $display("FAIL spur_addr got %b want %b", obs, 8'b1000_0100);
    end
    mem_ready = 0;
    tick; #1;
    compared++;
    if (obs !== 8'b0001_0100) begin
      mismatched++; $display("FAIL spur_rd_wait got %b want %b", obs, 8'b0001_0100);
    end
    mem_ready = 1;
    #1;
    compared++;
    if (obs !== 8'b0111_0100) begin
      mismatched++; $display("FAIL spur_complete got %b want %b", obs, 8'b0111_0100);
    end
    tick; mem_ready = 0; #1;
    compared++;
    if (done !== 1'b1 || mdr !== 32'h0000_CAFE) begin
      mismatched++; $display("FAIL spur_done got done=%b mdr %h want done=1 mdr %h", done, mdr, 32'hCAFE);
    end
  endtask

  initial begin
    test_reset;
    test_read_zero_wait;
    test_write_wait3;
    test_timeout;
    test_simul_ignored;
    test_reset_mid_op;
    test_spurious_ready;
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences one memory transaction at a time through the MAR/MDR pair and the external RAM.
- Sits between the control unit and the datapath. Accepts single-cycle read/write requests and generates MARin, MDRin and Read strobes plus RAM mem_rd/mem_wr.
- Waits on the RAM ready handshake with a bounded timeout, then reports done or error.
- Control-only: no data bits pass through this block.

Parameters:
TIMEOUT, 15, max cycles spent waiting for mem_ready in a wait state before abort (legal range 1..255)
CNT_W, 8, width of wait counter (must hold TIMEOUT)

Ports:
clk  input  1  system clock, all state changes on rising edge
clr_n  input  1  asynchronous active-low clear
req_rd  input  1  read request pulse from control unit, sampled only in IDLE
req_wr  input  1  write request pulse from control unit, sampled only in IDLE
mem_ready  input  1  RAM acknowledge: read data valid on Mdatain / write committed
err_clr  input  1  clears sticky err flag
MARin  output  1  load MAR from bus
MDRin  output  1  enable MDR load
Read  output  1  MDR source select: 1 = Mdatain, 0 = BusMuxOut
mem_rd  output  1  RAM read strobe
mem_wr  output  1  RAM write strobe (RAM takes address from MAR, data from MDR)
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on successful completion
err  output  1  sticky timeout flag

Behaviour:
- Reset: clr_n low forces state IDLE, counter 0, err 0 and all outputs 0 immediately (asynchronous), including mid-transaction. No partial strobe survives reset.
- Outputs are Moore-decoded from state, except MDRin/Read in RD_WAIT and the exit from WR_WAIT, which are qualified by mem_ready (Mealy).
- IDLE: busy=0.
  - req_rd=1 -> ADDR, op=read.
  - else req_wr=1 -> ADDR, op=write.
  - Both high: read wins, write is dropped.
  - Requests outside IDLE are ignored, not queued.
- ADDR: MARin=1 for exactly one cycle.
  - Read -> RD_WAIT.
  - Write -> WR_LOAD.
  - Counter cleared.
- RD_WAIT: mem_rd=1.
  - mem_ready=1: MDRin=1 and Read=1 in the same cycle (MDR captures Mdatain at this edge) -> DONE.
  - Else counter++. When counter == TIMEOUT-1 and still no ready -> ERR.
- WR_LOAD: MDRin=1, Read=0 for one cycle (MDR captures BusMuxOut) -> WR_WAIT, counter cleared.
- WR_WAIT: mem_wr=1.
  - mem_ready=1 -> DONE.
  - Else counter++ with the same timeout rule -> ERR.
- DONE: done=1, busy=1 for one cycle -> IDLE.
- ERR: err set, busy=1 for one cycle -> IDLE. No MDR load occurs on the timeout path.
- err remains set until err_clr=1 (cleared at the next edge) or reset. If err_clr is high in the same cycle as ERR, set wins.
- mem_ready outside RD_WAIT/WR_WAIT is ignored.
- Latency with mem_ready already high, counted from the request-sample edge E0:
  - Read: MARin in cycle 1, mem_rd+MDRin+Read in cycle 2, done in cycle 3.
  - Write: MARin cycle 1, MDRin cycle 2, mem_wr cycle 3, done cycle 4.
- Each added wait cycle adds one cycle to these latencies.
- Timeout: exactly TIMEOUT cycles of strobe without ready, then ERR.
- Strobes never overlap: at most one of MARin, MDRin, mem_rd, mem_wr is high, except MDRin with mem_rd in the RD_WAIT completion cycle.

Decomposition:
- Shared cpu package holds the state enum (IDLE, ADDR, RD_WAIT, WR_LOAD, WR_WAIT, DONE, ERR) and the TIMEOUT default constant.
- One natural sub-module, wait_timer: a CNT_W-bit counter with clear, enable and terminal-count (== TIMEOUT-1) output, instantiated once.
- The FSM and output decode stay in the top module.

Test Plan:
- Read, zero wait: pulse req_rd, mem_ready tied 1. Expect MARin at cycle 1; mem_rd=MDRin=Read=1 at cycle 2; done at cycle 3. MDR holds the Mdatain value 0x0000_1234 afterwards; busy low at cycle 4.
- Write, 3 wait cycles: req_wr, BusMuxOut=0xDEAD_BEEF, mem_ready raised on the 4th WR_WAIT cycle. Expect MDRin=1/Read=0 at cycle 2, mem_wr high for cycles 3-6, done at cycle 7, MDR=0xDEAD_BEEF.
- Timeout: TIMEOUT=4, req_rd, mem_ready held 0. Expect mem_rd high for exactly 4 cycles and no MDRin. err rises and stays high through 10 idle cycles until err_clr, then clears next edge.
- Simultaneous and ignored requests: req_rd=req_wr=1 in IDLE -> read sequence only. A req_wr pulse during RD_WAIT produces no second transaction.
- Reset mid-op: drop clr_n during WR_WAIT. All outputs 0 asynchronously, before the next clk edge. After release, the FSM is in IDLE; a new req_rd completes normally.
- Spurious ready: mem_ready pulsed in IDLE and ADDR. Expect no done, no MDRin, and correct completion of the subsequent read.
